// File: rtl/ip_hdr_assembler_pkg.sv
// Shared types and widths for the IP header assembler frontend.
// The interface width macros are defined here when no outer include has set them.

`ifndef IP_ADDR_W
`define IP_ADDR_W 32
`endif
`ifndef TOT_LEN_W
`define TOT_LEN_W 16
`endif
`ifndef PROTOCOL_W
`define PROTOCOL_W 8
`endif
`ifndef MAC_INTERFACE_W
`define MAC_INTERFACE_W 64
`endif
`ifndef MAC_PADBYTES_W
`define MAC_PADBYTES_W 3
`endif

package ip_hdr_assembler_pkg;

    localparam int IP_ADDR_W       = `IP_ADDR_W;
    localparam int TOT_LEN_W       = `TOT_LEN_W;
    localparam int PROTOCOL_W      = `PROTOCOL_W;
    localparam int MAC_INTERFACE_W = `MAC_INTERFACE_W;
    localparam int MAC_PADBYTES_W  = `MAC_PADBYTES_W;

    // Per-packet tracking data carried alongside the header request.
    typedef struct packed {
        logic [31:0] tx_cycle;
        logic [31:0] pkt_seq;
    } tracker_stats_struct;

    localparam int TRACKER_STATS_W = $bits(tracker_stats_struct);

    // Packet-granular arbiter states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    // One header request as seen on the assembler request channel.
    typedef struct packed {
        logic [IP_ADDR_W-1:0]  src_ip;
        logic [IP_ADDR_W-1:0]  dst_ip;
        logic [TOT_LEN_W-1:0]  payload_len;
        logic [PROTOCOL_W-1:0] protocol;
        tracker_stats_struct   timestamp;
    } ip_assembler_req_struct;

    localparam int IP_ASSEMBLER_REQ_STRUCT_W = $bits(ip_assembler_req_struct);

endpackage

// File: rtl/ip_hdr_assembler_arb_rr_pick.sv
// Combinational round-robin priority picker.
// Searches upward from the entry after last_grant, wrapping, and returns the
// first requester found. The most recent grant therefore has lowest priority.

module ip_hdr_assembler_arb_rr_pick #(
    parameter int NUM_SRCS = 4,
    parameter int SRC_W    = $clog2(NUM_SRCS)
) (
    input  logic [NUM_SRCS-1:0] req,
    input  logic [SRC_W-1:0]    last_grant,
    output logic [SRC_W-1:0]    winner,
    output logic                any
);

    // Scan candidates last_grant+1 .. last_grant+NUM_SRCS (mod NUM_SRCS).
    always_comb begin
        logic [SRC_W-1:0] idx;
        int               cand;
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        cand   = 0;
        for (int i = 1; i <= NUM_SRCS; i++) begin
            cand = (int'(last_grant) + i) % NUM_SRCS;
            idx  = SRC_W'(cand);
            if (!any && req[idx]) begin
                winner = idx;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ip_hdr_assembler_arb.sv
// Packet-granular round-robin arbiter sharing one header assembler between
// NUM_SRCS requesters (NUM_SRCS must be at least 2). A grant covers one
// request handshake followed by that source's data beats through last.
//
// state | meaning
// IDLE  | no grant held; pick the next requester round-robin
// REQ   | forwarding the granted source's header request
// DATA  | forwarding the granted source's data beats until last

module ip_hdr_assembler_arb
    import ip_hdr_assembler_pkg::*;
#(
    parameter int NUM_SRCS = 4,
    parameter int SRC_W    = $clog2(NUM_SRCS)
) (
    input  logic                                   clk,
    input  logic                                   rst,

    input  logic [NUM_SRCS-1:0]                    src_arb_req_val,
    input  logic [NUM_SRCS*`IP_ADDR_W-1:0]         src_arb_src_ip_addr,
    input  logic [NUM_SRCS*`IP_ADDR_W-1:0]         src_arb_dst_ip_addr,
    input  logic [NUM_SRCS*`TOT_LEN_W-1:0]         src_arb_data_payload_len,
    input  logic [NUM_SRCS*`PROTOCOL_W-1:0]        src_arb_protocol,
    input  logic [NUM_SRCS*TRACKER_STATS_W-1:0]    src_arb_timestamp,
    output logic [NUM_SRCS-1:0]                    arb_src_req_rdy,

    input  logic [NUM_SRCS-1:0]                    src_arb_data_val,
    input  logic [NUM_SRCS*`MAC_INTERFACE_W-1:0]   src_arb_data,
    input  logic [NUM_SRCS-1:0]                    src_arb_data_last,
    input  logic [NUM_SRCS*`MAC_PADBYTES_W-1:0]    src_arb_data_padbytes,
    output logic [NUM_SRCS-1:0]                    arb_src_data_rdy,

    output logic                                   arb_assembler_req_val,
    output logic [`IP_ADDR_W-1:0]                  arb_assembler_src_ip_addr,
    output logic [`IP_ADDR_W-1:0]                  arb_assembler_dst_ip_addr,
    output logic [`TOT_LEN_W-1:0]                  arb_assembler_data_payload_len,
    output logic [`PROTOCOL_W-1:0]                 arb_assembler_protocol,
    output logic [TRACKER_STATS_W-1:0]             arb_assembler_timestamp,
    input  logic                                   assembler_arb_req_rdy,

    output logic                                   arb_assembler_data_val,
    output logic [`MAC_INTERFACE_W-1:0]            arb_assembler_data,
    output logic                                   arb_assembler_data_last,
    output logic [`MAC_PADBYTES_W-1:0]             arb_assembler_data_padbytes,
    input  logic                                   assembler_arb_data_rdy,

    output logic [SRC_W-1:0]                       arb_cur_src,
    output logic [31:0]                            arb_pkt_cnt
);

    arb_state_e                 state_q, state_d;
    logic [SRC_W-1:0]           grant_idx_q, grant_idx_d;
    logic [SRC_W-1:0]           last_grant_q, last_grant_d;
    logic [31:0]                pkt_cnt_q, pkt_cnt_d;

    logic [SRC_W-1:0]           pick_winner;
    logic                       pick_any;

    ip_assembler_req_struct     req_arr  [NUM_SRCS];
    logic [`MAC_INTERFACE_W-1:0] data_arr [NUM_SRCS];
    logic [`MAC_PADBYTES_W-1:0] pad_arr  [NUM_SRCS];
    ip_assembler_req_struct     sel_req;

    logic                       req_hs;
    logic                       last_hs;

    // Slice the flattened per-source buses; source i owns bits [(i+1)*W-1 : i*W].
    for (genvar i = 0; i < NUM_SRCS; i++) begin : g_unpack
        assign req_arr[i] = {
            src_arb_src_ip_addr     [i*IP_ADDR_W       +: IP_ADDR_W],
            src_arb_dst_ip_addr     [i*IP_ADDR_W       +: IP_ADDR_W],
            src_arb_data_payload_len[i*TOT_LEN_W       +: TOT_LEN_W],
            src_arb_protocol        [i*PROTOCOL_W      +: PROTOCOL_W],
            src_arb_timestamp       [i*TRACKER_STATS_W +: TRACKER_STATS_W]
        };
        assign data_arr[i] = src_arb_data         [i*MAC_INTERFACE_W +: MAC_INTERFACE_W];
        assign pad_arr[i]  = src_arb_data_padbytes[i*MAC_PADBYTES_W  +: MAC_PADBYTES_W];
    end

    ip_hdr_assembler_arb_rr_pick #(
        .NUM_SRCS (NUM_SRCS),
        .SRC_W    (SRC_W)
    ) u_rr_pick (
        .req        (src_arb_req_val),
        .last_grant (last_grant_q),
        .winner     (pick_winner),
        .any        (pick_any)
    );

    // Payload muxes follow the registered grant regardless of state; only the
    // valid/ready qualifiers below depend on the state.
    assign sel_req                        = req_arr[grant_idx_q];
    assign arb_assembler_src_ip_addr      = sel_req.src_ip;
    assign arb_assembler_dst_ip_addr      = sel_req.dst_ip;
    assign arb_assembler_data_payload_len = sel_req.payload_len;
    assign arb_assembler_protocol         = sel_req.protocol;
    assign arb_assembler_timestamp        = sel_req.timestamp;
    assign arb_assembler_data             = data_arr[grant_idx_q];
    assign arb_assembler_data_last        = src_arb_data_last[grant_idx_q];
    assign arb_assembler_data_padbytes    = pad_arr[grant_idx_q];

    assign arb_cur_src = grant_idx_q;
    assign arb_pkt_cnt = pkt_cnt_q;

    assign req_hs  = (state_q == REQ) && src_arb_req_val[grant_idx_q] && assembler_arb_req_rdy;
    assign last_hs = (state_q == DATA) && src_arb_data_val[grant_idx_q]
                     && assembler_arb_data_rdy && src_arb_data_last[grant_idx_q];

    // Valid and ready pass-through, gated by state and the granted source.
    always_comb begin
        arb_assembler_req_val  = 1'b0;
        arb_assembler_data_val = 1'b0;
        arb_src_req_rdy        = '0;
        arb_src_data_rdy       = '0;
        case (state_q)
            REQ: begin
                arb_assembler_req_val        = src_arb_req_val[grant_idx_q];
                arb_src_req_rdy[grant_idx_q] = assembler_arb_req_rdy;
            end
            DATA: begin
                arb_assembler_data_val        = src_arb_data_val[grant_idx_q];
                arb_src_data_rdy[grant_idx_q] = assembler_arb_data_rdy;
            end
            default: ;
        endcase
    end

    // Next-state: arbitrate in IDLE, hold the grant until the last-beat handshake.
    always_comb begin
        state_d      = state_q;
        grant_idx_d  = grant_idx_q;
        last_grant_d = last_grant_q;
        pkt_cnt_d    = pkt_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_idx_d = pick_winner;
                    state_d     = REQ;
                end
            end
            REQ: begin
                // A source that drops val here simply stalls its own grant.
                if (req_hs) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (last_hs) begin
                    last_grant_d = grant_idx_q;
                    pkt_cnt_d    = pkt_cnt_q + 32'd1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            grant_idx_q  <= '0;
            last_grant_q <= SRC_W'(NUM_SRCS - 1);
            pkt_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_idx_q  <= grant_idx_d;
            last_grant_q <= last_grant_d;
            pkt_cnt_q    <= pkt_cnt_d;
        end
    end

endmodule

// File: tb/tb_ip_hdr_assembler_arb.sv
// Bench for ip_hdr_assembler_arb: per-source packet models, a scoreboard of
// expected headers and beats in expected grant order, a table of single-packet
// vectors and hand-written multi-source sequences.

module tb_ip_hdr_assembler_arb;
    import ip_hdr_assembler_pkg::*;

    localparam int N     = 4;
    localparam int SW    = 2;
    localparam int IPW   = IP_ADDR_W;
    localparam int LENW  = TOT_LEN_W;
    localparam int PROW  = PROTOCOL_W;
    localparam int TSW   = TRACKER_STATS_W;
    localparam int MACW  = MAC_INTERFACE_W;
    localparam int PADW  = MAC_PADBYTES_W;

    logic               clk;
    logic               rst;
    logic [N-1:0]       src_arb_req_val;
    logic [N*IPW-1:0]   src_arb_src_ip_addr;
    logic [N*IPW-1:0]   src_arb_dst_ip_addr;
    logic [N*LENW-1:0]  src_arb_data_payload_len;
    logic [N*PROW-1:0]  src_arb_protocol;
    logic [N*TSW-1:0]   src_arb_timestamp;
    logic [N-1:0]       arb_src_req_rdy;
    logic [N-1:0]       src_arb_data_val;
    logic [N*MACW-1:0]  src_arb_data;
    logic [N-1:0]       src_arb_data_last;
    logic [N*PADW-1:0]  src_arb_data_padbytes;
    logic [N-1:0]       arb_src_data_rdy;
    logic               arb_assembler_req_val;
    logic [IPW-1:0]     arb_assembler_src_ip_addr;
    logic [IPW-1:0]     arb_assembler_dst_ip_addr;
    logic [LENW-1:0]    arb_assembler_data_payload_len;
    logic [PROW-1:0]    arb_assembler_protocol;
    logic [TSW-1:0]     arb_assembler_timestamp;
    logic               assembler_arb_req_rdy;
    logic               arb_assembler_data_val;
    logic [MACW-1:0]    arb_assembler_data;
    logic               arb_assembler_data_last;
    logic [PADW-1:0]    arb_assembler_data_padbytes;
    logic               assembler_arb_data_rdy;
    logic [SW-1:0]      arb_cur_src;
    logic [31:0]        arb_pkt_cnt;

    ip_hdr_assembler_arb #(.NUM_SRCS(N)) dut (
        .clk                            (clk),
        .rst                            (rst),
        .src_arb_req_val                (src_arb_req_val),
        .src_arb_src_ip_addr            (src_arb_src_ip_addr),
        .src_arb_dst_ip_addr            (src_arb_dst_ip_addr),
        .src_arb_data_payload_len       (src_arb_data_payload_len),
        .src_arb_protocol               (src_arb_protocol),
        .src_arb_timestamp              (src_arb_timestamp),
        .arb_src_req_rdy                (arb_src_req_rdy),
        .src_arb_data_val               (src_arb_data_val),
        .src_arb_data                   (src_arb_data),
        .src_arb_data_last              (src_arb_data_last),
        .src_arb_data_padbytes          (src_arb_data_padbytes),
        .arb_src_data_rdy               (arb_src_data_rdy),
        .arb_assembler_req_val          (arb_assembler_req_val),
        .arb_assembler_src_ip_addr      (arb_assembler_src_ip_addr),
        .arb_assembler_dst_ip_addr      (arb_assembler_dst_ip_addr),
        .arb_assembler_data_payload_len (arb_assembler_data_payload_len),
        .arb_assembler_protocol         (arb_assembler_protocol),
        .arb_assembler_timestamp        (arb_assembler_timestamp),
        .assembler_arb_req_rdy          (assembler_arb_req_rdy),
        .arb_assembler_data_val         (arb_assembler_data_val),
        .arb_assembler_data             (arb_assembler_data),
        .arb_assembler_data_last        (arb_assembler_data_last),
        .arb_assembler_data_padbytes    (arb_assembler_data_padbytes),
        .assembler_arb_data_rdy         (assembler_arb_data_rdy),
        .arb_cur_src                    (arb_cur_src),
        .arb_pkt_cnt                    (arb_pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Source models
    int  pend    [N];
    int  nb      [N];
    int  pkt_id  [N];
    int  beat    [N];
    bit  in_data [N];
    bit  req_fire[N];
    bit  dat_fire[N];
    bit  tog_rdy;

    int  checks;
    int  failures;
    int  beats_seen;
    int  exp_cnt;
    int  exp_id  [N];

    typedef struct {
        logic [MACW-1:0] data;
        logic            last;
        logic [PADW-1:0] pad;
        int              src;
    } beat_t;

    ip_assembler_req_struct exp_hdr_q[$];
    int                     exp_hdr_src_q[$];
    beat_t                  exp_beat_q[$];

    typedef struct {
        int src;
        int nbeats;
        bit toggle;
        int exp_src;
        int exp_beats;
    } vec_t;

    vec_t vecs[4];

    function automatic ip_assembler_req_struct make_hdr(input int s, input int id);
        ip_assembler_req_struct h;
        h.src_ip             = {8'h0A, 8'(s), 16'(id)};
        h.dst_ip             = 32'hC0A8_0000 + 32'(id * 7 + s);
        h.payload_len        = 16'(id * 13 + s * 100);
        h.protocol           = 8'(6 + s * 11);
        h.timestamp.tx_cycle = 32'(s * 1000 + id);
        h.timestamp.pkt_seq  = 32'(id);
        return h;
    endfunction

    function automatic logic [MACW-1:0] make_data(input int s, input int id, input int b);
        return MACW'({16'(16'hD000 + s), 16'(id), 32'(b)});
    endfunction

    function automatic logic [PADW-1:0] make_pad(input int s, input int b);
        return PADW'(b + s);
    endfunction

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_srcs();
        logic [N-1:0]      rv, dv, lv;
        logic [N*IPW-1:0]  sip, dip;
        logic [N*LENW-1:0] len;
        logic [N*PROW-1:0] pro;
        logic [N*TSW-1:0]  ts;
        logic [N*MACW-1:0] dat;
        logic [N*PADW-1:0] pad;
        ip_assembler_req_struct h;
        for (int i = 0; i < N; i++) begin
            h = make_hdr(i, pkt_id[i]);
            rv[i]                    = (pend[i] > 0) && !in_data[i];
            sip[i*IPW +: IPW]        = h.src_ip;
            dip[i*IPW +: IPW]        = h.dst_ip;
            len[i*LENW +: LENW]      = h.payload_len;
            pro[i*PROW +: PROW]      = h.protocol;
            ts[i*TSW +: TSW]         = h.timestamp;
            dv[i]                    = in_data[i];
            lv[i]                    = in_data[i] && (beat[i] == nb[i] - 1);
            dat[i*MACW +: MACW]      = make_data(i, pkt_id[i], beat[i]);
            pad[i*PADW +: PADW]      = make_pad(i, beat[i]);
        end
        src_arb_req_val          = rv;
        src_arb_src_ip_addr      = sip;
        src_arb_dst_ip_addr      = dip;
        src_arb_data_payload_len = len;
        src_arb_protocol         = pro;
        src_arb_timestamp        = ts;
        src_arb_data_val         = dv;
        src_arb_data_last        = lv;
        src_arb_data             = dat;
        src_arb_data_padbytes    = pad;
    endtask

    // Queue one expected packet (header + beats) for source s in grant order.
    task automatic expect_pkt(input int s);
        beat_t bt;
        exp_hdr_q.push_back(make_hdr(s, exp_id[s]));
        exp_hdr_src_q.push_back(s);
        for (int b = 0; b < nb[s]; b++) begin
            bt.data = make_data(s, exp_id[s], b);
            bt.last = (b == nb[s] - 1);
            bt.pad  = make_pad(s, b);
            bt.src  = s;
            exp_beat_q.push_back(bt);
        end
        exp_id[s]++;
    endtask

    // One clock: monitor at negedge, then advance source models after posedge.
    task automatic step();
        ip_assembler_req_struct ah, eh;
        beat_t eb;
        int es;
        @(negedge clk);
        if (arb_assembler_req_val && assembler_arb_req_rdy) begin
            if (exp_hdr_q.size() == 0) begin
                chk("unexpected_req", 160'(1), 160'(0));
            end else begin
                eh = exp_hdr_q.pop_front();
                es = exp_hdr_src_q.pop_front();
                ah.src_ip      = arb_assembler_src_ip_addr;
                ah.dst_ip      = arb_assembler_dst_ip_addr;
                ah.payload_len = arb_assembler_data_payload_len;
                ah.protocol    = arb_assembler_protocol;
                ah.timestamp   = arb_assembler_timestamp;
                chk("req_src", 160'(arb_cur_src), 160'(es));
                chk("req_hdr", 160'(ah), 160'(eh));
            end
        end
        if (arb_assembler_data_val && assembler_arb_data_rdy) begin
            beats_seen++;
            if (exp_beat_q.size() == 0) begin
                chk("unexpected_beat", 160'(1), 160'(0));
            end else begin
                eb = exp_beat_q.pop_front();
                chk("beat_src", 160'(arb_cur_src), 160'(eb.src));
                chk("beat_data", 160'({arb_assembler_data, arb_assembler_data_last, arb_assembler_data_padbytes}),
                    160'({eb.data, eb.last, eb.pad}));
            end
        end
        chk("val_exclusive", 160'(arb_assembler_req_val && arb_assembler_data_val), 160'(0));
        for (int i = 0; i < N; i++) begin
            req_fire[i] = src_arb_req_val[i] && arb_src_req_rdy[i];
            dat_fire[i] = src_arb_data_val[i] && arb_src_data_rdy[i];
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (req_fire[i]) begin
                in_data[i] = 1'b1;
                beat[i]    = 0;
            end else if (dat_fire[i]) begin
                if (beat[i] == nb[i] - 1) begin
                    in_data[i] = 1'b0;
                    beat[i]    = 0;
                    pend[i]--;
                    pkt_id[i]++;
                end else begin
                    beat[i]++;
                end
            end
        end
        assembler_arb_data_rdy = tog_rdy ? ~assembler_arb_data_rdy : 1'b1;
        drive_srcs();
    endtask

    function automatic bit all_done();
        bit d;
        d = (exp_hdr_q.size() == 0) && (exp_beat_q.size() == 0);
        for (int i = 0; i < N; i++) begin
            if (pend[i] != 0 || in_data[i]) d = 1'b0;
        end
        return d;
    endfunction

    task automatic run_until_idle(input string name, input int budget);
        int n;
        n = 0;
        while (!all_done() && n < budget) begin
            step();
            n++;
        end
        chk({name, "_done"}, 160'(all_done()), 160'(1));
    endtask

    initial begin
        int base;
        int n;

        vecs[0] = '{src: 0, nbeats: 2, toggle: 1'b0, exp_src: 0, exp_beats: 2};
        vecs[1] = '{src: 1, nbeats: 5, toggle: 1'b1, exp_src: 1, exp_beats: 5};
        vecs[2] = '{src: 2, nbeats: 8, toggle: 1'b1, exp_src: 2, exp_beats: 8};
        vecs[3] = '{src: 3, nbeats: 1, toggle: 1'b0, exp_src: 3, exp_beats: 1};

        checks = 0; failures = 0; beats_seen = 0; exp_cnt = 0; tog_rdy = 1'b0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 0; nb[i] = 1; pkt_id[i] = 0; beat[i] = 0; in_data[i] = 1'b0;
            exp_id[i] = 0;
        end
        rst = 1'b0;
        assembler_arb_req_rdy  = 1'b1;
        assembler_arb_data_rdy = 1'b1;
        drive_srcs();
        step();
        step();

        // Reset state
        chk("rst_req_rdy",  160'(arb_src_req_rdy),        160'(0));
        chk("rst_data_rdy", 160'(arb_src_data_rdy),       160'(0));
        chk("rst_req_val",  160'(arb_assembler_req_val),  160'(0));
        chk("rst_data_val", 160'(arb_assembler_data_val), 160'(0));
        chk("rst_cur_src",  160'(arb_cur_src),            160'(0));
        chk("rst_pkt_cnt",  160'(arb_pkt_cnt),            160'(0));
        rst = 1'b1;

        // Single source 2, 3 beats: one bubble, request forwarded the next cycle
        nb[2] = 3;
        expect_pkt(2);
        pend[2] = 1;
        drive_srcs();
        chk("t1_bubble", 160'(arb_assembler_req_val), 160'(0));
        step();
        chk("t1_req_val", 160'(arb_assembler_req_val), 160'(1));
        chk("t1_cur_src", 160'(arb_cur_src),           160'(2));
        chk("t1_req_rdy", 160'(arb_src_req_rdy),       160'(4'b0100));
        base = beats_seen;
        run_until_idle("t1", 20);
        chk("t1_beats",    160'(beats_seen - base),     160'(3));
        exp_cnt = 1;
        chk("t1_pkt_cnt",  160'(arb_pkt_cnt),           160'(exp_cnt));
        chk("t1_idle_req", 160'(arb_assembler_req_val), 160'(0));
        chk("t1_idle_dat", 160'(arb_assembler_data_val),160'(0));

        // Table of single-packet vectors
        for (int v = 0; v < 4; v++) begin
            nb[vecs[v].src] = vecs[v].nbeats;
            tog_rdy = vecs[v].toggle;
            expect_pkt(vecs[v].src);
            pend[vecs[v].src] = 1;
            drive_srcs();
            base = beats_seen;
            run_until_idle("vec", 80);
            chk("vec_cur_src", 160'(arb_cur_src),       160'(vecs[v].exp_src));
            chk("vec_beats",   160'(beats_seen - base), 160'(vecs[v].exp_beats));
            exp_cnt++;
            chk("vec_pkt_cnt", 160'(arb_pkt_cnt),       160'(exp_cnt));
            tog_rdy = 1'b0;
            assembler_arb_data_rdy = 1'b1;
        end

        // All four requesting, 1-beat packets: order 0,1,2,3,0,1 at 3 cycles each
        for (int i = 0; i < N; i++) nb[i] = 1;
        expect_pkt(0); expect_pkt(1); expect_pkt(2); expect_pkt(3);
        expect_pkt(0); expect_pkt(1);
        pend[0] = 2; pend[1] = 2; pend[2] = 1; pend[3] = 1;
        drive_srcs();
        n = 0;
        while (arb_pkt_cnt != 32'(exp_cnt + 6) && n < 60) begin
            step();
            n++;
        end
        chk("t2_cycles", 160'(n), 160'(18));
        run_until_idle("t2", 20);
        exp_cnt += 6;
        chk("t2_pkt_cnt", 160'(arb_pkt_cnt), 160'(exp_cnt));

        // Source 0 requests while source 1 is mid-packet
        nb[1] = 4;
        expect_pkt(1);
        pend[1] = 1;
        drive_srcs();
        n = 0;
        while (!(in_data[1] && beat[1] == 1) && n < 20) begin
            step();
            n++;
        end
        chk("t3_reached_beat2", 160'(in_data[1] && beat[1] == 1), 160'(1));
        nb[0] = 1;
        expect_pkt(0);
        pend[0] = 1;
        drive_srcs();
        chk("t3_src0_blocked", 160'(arb_src_req_rdy[0]), 160'(0));
        n = 0;
        while (in_data[1] && n < 20) begin
            step();
            n++;
            if (in_data[1]) chk("t3_src0_blocked", 160'(arb_src_req_rdy[0]), 160'(0));
        end
        step();
        chk("t3_next_grant", 160'(arb_cur_src),     160'(0));
        chk("t3_src0_rdy",   160'(arb_src_req_rdy), 160'(4'b0001));
        run_until_idle("t3", 20);
        exp_cnt += 2;
        chk("t3_pkt_cnt", 160'(arb_pkt_cnt), 160'(exp_cnt));

        // Reset during source 3's DATA phase
        nb[3] = 4;
        expect_pkt(3);
        pend[3] = 1;
        drive_srcs();
        n = 0;
        while (!(in_data[3] && beat[3] == 1) && n < 20) begin
            step();
            n++;
        end
        chk("t5_in_data", 160'(in_data[3] && beat[3] == 1), 160'(1));
        rst = 1'b0;
        step();
        chk("t5_req_rdy",  160'(arb_src_req_rdy),        160'(0));
        chk("t5_data_rdy", 160'(arb_src_data_rdy),       160'(0));
        chk("t5_req_val",  160'(arb_assembler_req_val),  160'(0));
        chk("t5_data_val", 160'(arb_assembler_data_val), 160'(0));
        chk("t5_pkt_cnt",  160'(arb_pkt_cnt),            160'(0));
        chk("t5_cur_src",  160'(arb_cur_src),            160'(0));
        for (int i = 0; i < N; i++) begin
            pend[i] = 0; in_data[i] = 1'b0; beat[i] = 0; pkt_id[i] = exp_id[i];
        end
        exp_hdr_q.delete();
        exp_hdr_src_q.delete();
        exp_beat_q.delete();
        exp_cnt = 0;
        rst = 1'b1;
        nb[0] = 1; nb[2] = 1; nb[3] = 1;
        expect_pkt(0); expect_pkt(2); expect_pkt(3);
        pend[0] = 1; pend[2] = 1; pend[3] = 1;
        drive_srcs();
        step();
        chk("t5_first_grant", 160'(arb_cur_src), 160'(0));
        run_until_idle("t5", 30);
        exp_cnt = 3;
        chk("t5_pkt_cnt_after", 160'(arb_pkt_cnt), 160'(exp_cnt));

        // Packet counter wraps from all-ones to zero
        force dut.pkt_cnt_q = 32'hFFFF_FFFF;
        step();
        release dut.pkt_cnt_q;
        chk("t6_preload", 160'(arb_pkt_cnt), 160'(32'hFFFF_FFFF));
        nb[1] = 1;
        expect_pkt(1);
        pend[1] = 1;
        drive_srcs();
        run_until_idle("t6", 20);
        chk("t6_wrap", 160'(arb_pkt_cnt), 160'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
